frame_slot_ctrl: RTL and testbench

- Scheduler for the five-slot SDRAM frame buffer.
- Write side: sequences UART bytes into consecutive frame slots, tracks the word count per slot, and marks each slot valid when it is complete.
- Read side: debounces the slot-select switches, updates the VGA read window, and issues a timed active-low reload pulse to the SDRAM controller's LOAD/reset path.
- Sits between uart_rx / SW and Sdram_Control / Reset_Delay.

---
 rtl/frame_slot_pkg.sv | 29 ++
 rtl/frame_slot_ctrl_sel_debounce.sv | 84 ++++++++
 rtl/frame_slot_ctrl.sv | 144 ++++++++++++++
 tb/tb_frame_slot_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_slot_pkg.sv
// Shared definitions for the frame-slot scheduler.
//   SLOT_WORDS_DEF : default words per slot (one 640x480 frame)
//   SLOT_IDX_W     : width of a slot index
//   ADDR_W         : SDRAM word-address width
//   rd_state_e     : read-side FSM states
//   slot_base()    : base word address of a slot, built by accumulation
package frame_slot_pkg;

  localparam int SLOT_WORDS_DEF = 307200;
  localparam int SLOT_IDX_W     = 3;
  localparam int ADDR_W         = 23;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_PEND   = 2'd1,
    RS_RELOAD = 2'd2
  } rd_state_e;

  // idx*words without a multiplier: a constant-bound chain of conditional adds.
  function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_IDX_W-1:0] idx,
                                                  input int unsigned            words);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < (1 << SLOT_IDX_W) - 1; i++)
      if (SLOT_IDX_W'(i) < idx) acc = acc + ADDR_W'(words);
    return acc;
  endfunction

endpackage

// File: rtl/frame_slot_ctrl_sel_debounce.sv
// Read-side selection FSM: debounces the decoded slot select, commits it,
// then holds a fixed-length active-low reload pulse.
//   clk, rst_n : clock, async active-low reset
//   sel        : decoded slot selection (combinational from the switches)
//   slot       : committed (displayed) slot
//   commit     : one-cycle pulse, high in the cycle whose edge commits sel
//   reload_n   : active-low reload pulse, starts the cycle after commit
//   busy       : FSM not idle
module sel_debounce
  import frame_slot_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int RELOAD_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLOT_IDX_W-1:0] sel,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic                  commit,
  output logic                  reload_n,
  output logic                  busy
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RW = (RELOAD_CYC > 1) ? $clog2(RELOAD_CYC) : 1;

  rd_state_e             state;
  logic [SLOT_IDX_W-1:0] cand;
  logic [DW-1:0]         stab_cnt;
  logic [RW-1:0]         rl_cnt;

  // Commit only when the candidate is still present and still differs from
  // what is displayed; a bounce back to the current slot cancels instead.
  assign commit = (state == RS_PEND) && (sel == cand) && (sel != slot) &&
                  (stab_cnt == DW'(DEBOUNCE_CYC - 1));
  assign busy   = (state != RS_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RS_IDLE;
      cand     <= '0;
      stab_cnt <= '0;
      rl_cnt   <= '0;
      slot     <= '0;
      reload_n <= 1'b1;
    end else begin
      case (state)
        RS_IDLE: begin
          if (sel != slot) begin
            cand     <= sel;
            stab_cnt <= '0;
            state    <= RS_PEND;
          end
        end
        RS_PEND: begin
          if (sel == slot) begin
            state <= RS_IDLE;
          end else if (sel != cand) begin
            cand     <= sel;
            stab_cnt <= '0;
          end else if (commit) begin
            slot     <= cand;
            rl_cnt   <= '0;
            reload_n <= 1'b0;
            state    <= RS_RELOAD;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        RS_RELOAD: begin
          // Switch activity is ignored here; IDLE re-evaluates it afterwards.
          if (rl_cnt == RW'(RELOAD_CYC - 1)) begin
            reload_n <= 1'b1;
            state    <= RS_IDLE;
          end else begin
            rl_cnt <= rl_cnt + 1'b1;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frame_slot_ctrl.sv
// Five-slot SDRAM frame-buffer scheduler.
// Write side sequences UART bytes into consecutive slots and flags complete
// slots; read side debounces the slot switches, moves the VGA read window and
// pulses the SDRAM controller reload.
//   iCLK, iRST_N          : clock, async active-low reset
//   iSEL                  : slot switches, bit k -> slot k+1, lowest bit wins
//   iRX_VALID, iRX_DATA   : byte strobe / byte from uart_rx
//   oWR_REQ/DATA/ADDR     : write strobe, {8'h00,byte}, slot base + word count
//   oWR_SLOT              : slot being filled
//   oFRAME_DONE           : pulse with the last word of a slot
//   oSLOT_VALID           : per-slot complete flags
//   oRD_SLOT/ADDR/MAX_ADDR: displayed slot and its read window
//   oRELOAD_N             : active-low reload pulse
//   oBUSY                 : read FSM not idle
module frame_slot_ctrl
  import frame_slot_pkg::*;
#(
  parameter int NUM_SLOTS    = 5,
  parameter int SLOT_WORDS   = SLOT_WORDS_DEF,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int RELOAD_CYC   = 16,
  parameter int IDLE_TIMEOUT = 5000000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [3:0]            iSEL,
  input  logic                  iRX_VALID,
  input  logic [7:0]            iRX_DATA,
  output logic                  oWR_REQ,
  output logic [15:0]           oWR_DATA,
  output logic [ADDR_W-1:0]     oWR_ADDR,
  output logic [SLOT_IDX_W-1:0] oWR_SLOT,
  output logic                  oFRAME_DONE,
  output logic [NUM_SLOTS-1:0]  oSLOT_VALID,
  output logic [SLOT_IDX_W-1:0] oRD_SLOT,
  output logic [ADDR_W-1:0]     oRD_ADDR,
  output logic [ADDR_W-1:0]     oRD_MAX_ADDR,
  output logic                  oRELOAD_N,
  output logic                  oBUSY
);

  localparam int                    IW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]     SW_A      = ADDR_W'(SLOT_WORDS);
  localparam logic [ADDR_W-1:0]     LAST_WORD = ADDR_W'(SLOT_WORDS - 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

  // ---------------- write sequencer ----------------
  logic [SLOT_IDX_W-1:0] wr_slot;
  logic [ADDR_W-1:0]     wr_base;   // running wr_slot*SLOT_WORDS
  logic [ADDR_W-1:0]     word_cnt;
  logic [IW-1:0]         idle_cnt;

  assign oWR_SLOT = wr_slot;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oWR_REQ     <= 1'b0;
      oWR_DATA    <= '0;
      oWR_ADDR    <= '0;
      oFRAME_DONE <= 1'b0;
      oSLOT_VALID <= '0;
      wr_slot     <= '0;
      wr_base     <= '0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      oWR_REQ     <= iRX_VALID;
      oFRAME_DONE <= 1'b0;
      if (iRX_VALID) begin
        oWR_DATA <= {8'h00, iRX_DATA};
        oWR_ADDR <= wr_base + word_cnt;
        idle_cnt <= '0;
        // Slot is being overwritten: it stops being valid with its first word.
        if (word_cnt == '0) oSLOT_VALID[wr_slot] <= 1'b0;
        if (word_cnt == LAST_WORD) begin
          oFRAME_DONE          <= 1'b1;
          oSLOT_VALID[wr_slot] <= 1'b1;
          word_cnt             <= '0;
          if (wr_slot == LAST_SLOT) begin
            wr_slot <= '0;
            wr_base <= '0;
          end else begin
            wr_slot <= wr_slot + 1'b1;
            wr_base <= wr_base + SW_A;
          end
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end else if (word_cnt != '0) begin
        // Stalled mid-frame: restart the same slot from word 0, flag stays low.
        if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
          word_cnt <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- read side ----------------
  logic [SLOT_IDX_W-1:0] sel_dec;
  logic [ADDR_W-1:0]     sel_base;
  logic                  commit;

  always_comb begin
    sel_dec = '0;
    casez (iSEL)
      4'b???1: sel_dec = 3'd1;
      4'b??10: sel_dec = 3'd2;
      4'b?100: sel_dec = 3'd3;
      4'b1000: sel_dec = 3'd4;
      default: sel_dec = 3'd0;
    endcase
  end

  assign sel_base = slot_base(sel_dec, SLOT_WORDS);

  sel_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .RELOAD_CYC  (RELOAD_CYC)
  ) u_sel (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .sel     (sel_dec),
    .slot    (oRD_SLOT),
    .commit  (commit),
    .reload_n(oRELOAD_N),
    .busy    (oBUSY)
  );

  // Window registered on the commit edge (sel_dec equals the candidate then),
  // so it moves together with oRD_SLOT and keeps the adder chain off the pins.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRD_ADDR     <= '0;
      oRD_MAX_ADDR <= SW_A;
    end else if (commit) begin
      oRD_ADDR     <= sel_base;
      oRD_MAX_ADDR <= sel_base + SW_A;
    end
  end

endmodule

// File: tb/tb_frame_slot_ctrl.sv
// Self-checking bench for frame_slot_ctrl with small parameters.
module tb_frame_slot_ctrl;

  localparam int SW = 8, NS = 5, DB = 4, RL = 3, IT = 20;

  logic        iCLK = 1'b0, iRST_N = 1'b0;
  logic [3:0]  iSEL = 4'b0000;
  logic        iRX_VALID = 1'b0;
  logic [7:0]  iRX_DATA = 8'h00;
  logic        oWR_REQ, oFRAME_DONE, oRELOAD_N, oBUSY;
  logic [15:0] oWR_DATA;
  logic [22:0] oWR_ADDR, oRD_ADDR, oRD_MAX_ADDR;
  logic [2:0]  oWR_SLOT, oRD_SLOT;
  logic [4:0]  oSLOT_VALID;

  frame_slot_ctrl #(
    .NUM_SLOTS(NS), .SLOT_WORDS(SW), .DEBOUNCE_CYC(DB),
    .RELOAD_CYC(RL), .IDLE_TIMEOUT(IT)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSEL(iSEL),
    .iRX_VALID(iRX_VALID), .iRX_DATA(iRX_DATA),
    .oWR_REQ(oWR_REQ), .oWR_DATA(oWR_DATA), .oWR_ADDR(oWR_ADDR),
    .oWR_SLOT(oWR_SLOT), .oFRAME_DONE(oFRAME_DONE), .oSLOT_VALID(oSLOT_VALID),
    .oRD_SLOT(oRD_SLOT), .oRD_ADDR(oRD_ADDR), .oRD_MAX_ADDR(oRD_MAX_ADDR),
    .oRELOAD_N(oRELOAD_N), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] data;
    logic        done;
  } wr_exp_t;

  wr_exp_t    sb[$];
  wr_exp_t    mon_e;
  int         n_cmp = 0, n_bad = 0;
  int         done_cnt = 0, exp_done = 0;
  int         m_slot = 0, m_cnt = 0;
  logic [4:0] m_valid = 5'b0;
  int         lows, first_low, first_commit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // Push the expected write, advance the reference model, then drive the byte.
  task automatic send_byte(input logic [7:0] b);
    wr_exp_t e;
    e.addr = 23'(m_slot * SW + m_cnt);
    e.data = {8'h00, b};
    e.done = (m_cnt == SW - 1);
    if (m_cnt == 0) m_valid[m_slot] = 1'b0;
    if (e.done) begin
      m_valid[m_slot] = 1'b1;
      m_cnt  = 0;
      m_slot = (m_slot + 1) % NS;
      exp_done++;
    end else begin
      m_cnt++;
    end
    sb.push_back(e);
    iRX_VALID = 1'b1;
    iRX_DATA  = b;
    @(posedge iCLK);
    #1;
    iRX_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    tick(n);
    if (n >= IT) m_cnt = 0;
  endtask

  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oFRAME_DONE) done_cnt++;
      if (oWR_REQ) begin
        if (sb.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("wr_addr", oWR_ADDR, mon_e.addr);
          chk("wr_data", oWR_DATA, mon_e.data);
          chk("wr_done", oFRAME_DONE, mon_e.done);
        end
      end else if (oFRAME_DONE) begin
        chk("done_without_req", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #23;
    chk("rst_reload_n", oRELOAD_N, 1);
    chk("rst_rd_addr", oRD_ADDR, 0);
    chk("rst_rd_max", oRD_MAX_ADDR, 8);
    chk("rst_valid", oSLOT_VALID, 5'b00000);
    chk("rst_wr_req", oWR_REQ, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_rd_slot", oRD_SLOT, 0);
    iRST_N = 1'b1;
    tick(2);

    // one full slot
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    tick(2);
    chk("slot0_valid", oSLOT_VALID, 5'b00001);
    chk("slot0_wr_slot", oWR_SLOT, 1);
    chk("slot0_done_cnt", done_cnt, 1);

    // fill to 40 bytes: every slot valid, write slot wraps
    for (int i = 8; i < 40; i++) send_byte(8'(i * 3));
    tick(2);
    chk("all_valid", oSLOT_VALID, 5'b11111);
    chk("wrap_wr_slot", oWR_SLOT, 0);
    send_byte(8'hC1);
    tick(2);
    chk("byte41_valid", oSLOT_VALID, 5'b11110);
    for (int i = 0; i < 7; i++) send_byte(8'hD0 + 8'(i));
    tick(2);
    chk("refill_valid", oSLOT_VALID, m_valid);
    chk("refill_wr_slot", oWR_SLOT, 1);

    // bounce shorter than the debounce window: no commit
    iSEL = 4'b0010;
    tick(2);
    iSEL = 4'b0000;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (!oRELOAD_N) lows++;
    end
    chk("bounce_reload_lows", lows, 0);
    chk("bounce_rd_slot", oRD_SLOT, 0);
    chk("bounce_busy", oBUSY, 0);

    // stable selection of slot 3
    iSEL = 4'b0100;
    lows = 0; first_low = -1; first_commit = -1;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (k == 0) chk("pend_busy", oBUSY, 1);
      if (first_commit < 0 && oRD_SLOT == 3) first_commit = k;
      if (!oRELOAD_N) begin
        lows++;
        if (first_low < 0) first_low = k;
      end
    end
    chk("sel3_rd_slot", oRD_SLOT, 3);
    chk("sel3_rd_addr", oRD_ADDR, 24);
    chk("sel3_rd_max", oRD_MAX_ADDR, 32);
    chk("sel3_commit_cycle", first_commit, DB);
    chk("sel3_reload_start", first_low, DB);
    chk("sel3_reload_len", lows, RL);

    // two switches up: lowest bit wins
    iSEL = 4'b0011;
    tick(12);
    chk("sel1_rd_slot", oRD_SLOT, 1);
    chk("sel1_rd_addr", oRD_ADDR, 8);
    chk("sel1_rd_max", oRD_MAX_ADDR, 16);
    chk("sel1_idle", oBUSY, 0);

    // idle timeout: short gap continues, long gap restarts the slot
    send_byte(8'h30);
    send_byte(8'h31);
    send_byte(8'h32);
    idle(15);
    send_byte(8'h33);
    idle(22);
    chk("abort_no_done", done_cnt, exp_done);
    send_byte(8'h34);
    tick(2);
    chk("abort_valid", oSLOT_VALID, m_valid);
    chk("abort_wr_slot", oWR_SLOT, 1);

    // reset asserted while the reload pulse is low
    iSEL = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      if (!oRELOAD_N) break;
      tick(1);
    end
    chk("reload_seen", oRELOAD_N, 0);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("async_rst_reload_n", oRELOAD_N, 1);
    chk("async_rst_rd_slot", oRD_SLOT, 0);
    chk("async_rst_rd_max", oRD_MAX_ADDR, 8);
    chk("async_rst_valid", oSLOT_VALID, 0);
    chk("async_rst_wr_slot", oWR_SLOT, 0);
    chk("async_rst_busy", oBUSY, 0);
    m_slot = 0; m_cnt = 0; m_valid = 5'b0;
    iSEL = 4'b0000;
    #2;
    iRST_N = 1'b1;
    tick(2);
    send_byte(8'hA5);
    tick(3);
    chk("post_rst_valid", oSLOT_VALID, m_valid);
    chk("post_rst_done_cnt", done_cnt, exp_done);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
